// File: rtl/mips_bus_pkg.sv
// Shared types and helpers for the CPU-side bus initiator and its watchdog.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bus_state_e;

    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BYTE_EN_W  = BUS_DATA_W / 8;

    // Drops the byte offset; callers cast to and from their own address width.
    function automatic logic [63:0] word_align(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Stall counter for the ACCESS phase; expired_o marks the cycle where one more
// stalled edge must abort the transfer.
module bus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic tick_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/bus_initiator.sv
// CPU-side Avalon-style bus initiator: one outstanding word transfer, IDLE -> ACCESS -> RESP.
// Define BUS_TIMEOUT_EN to abort a stalled ACCESS after TIMEOUT_CYCLES with resp_err.
module bus_initiator
    import mips_bus_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_byteenable,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic [ADDR_W-1:0]   address,
    output logic                write,
    output logic                read,
    input  logic                waitrequest,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   readdata
);
    localparam int unsigned BE_W = DATA_W / 8;

    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] writedata_q, writedata_d;
    logic [BE_W-1:0]   byteenable_q, byteenable_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              is_write_q, is_write_d;
    logic              resp_err_q, resp_err_d;
    logic              accept;
    logic              complete;
    logic              timeout_hit;

    assign accept   = (state_q == IDLE) && req_valid;
    assign complete = (state_q == ACCESS) && !waitrequest;

`ifdef BUS_TIMEOUT_EN
    logic wd_expired;

    bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (accept),
        .tick_i   ((state_q == ACCESS) && waitrequest),
        .expired_o(wd_expired)
    );

    // A completing edge never reaches this term, so completion wins over expiry.
    assign timeout_hit = (state_q == ACCESS) && waitrequest && wd_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    // NOTE: registers update with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            address_q    <= '0;
            writedata_q  <= '0;
            byteenable_q <= '0;
            resp_rdata_q <= '0;
            is_write_q   <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            writedata_q  <= writedata_d;
            byteenable_q <= byteenable_d;
            resp_rdata_q <= resp_rdata_d;
            is_write_q   <= is_write_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // NOTE: each next-state value starts from its current value, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ACCESS;
            ACCESS:  if (complete || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        address_d    = address_q;
        writedata_d  = writedata_q;
        byteenable_d = byteenable_q;
        is_write_d   = is_write_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (accept) begin
            address_d    = ADDR_W'(word_align(64'(req_addr)));
            writedata_d  = req_wdata;
            byteenable_d = req_byteenable;
            is_write_d   = req_write;
        end
        if (complete) begin
            resp_rdata_d = is_write_q ? '0 : readdata;
            resp_err_d   = 1'b0;
        end else if (timeout_hit) begin
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
        end
    end

    // Strobes exist only in ACCESS, which forces a strobe-free RESP cycle between transfers.
    always_comb begin
        req_ready  = (state_q == IDLE);
        read       = (state_q == ACCESS) && !is_write_q;
        write      = (state_q == ACCESS) && is_write_q;
        resp_valid = (state_q == RESP);
    end

    assign address    = address_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: directed requests against a small bus memory, with a
// transaction-level model predicting responses, strobes and latency every cycle.
module tb_bus_initiator;
    import mips_bus_pkg::*;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned TIMEOUT_CYCLES = 64;
    localparam int          NEVER          = 32'h7fff_ffff;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic                 req_write = 1'b0;
    logic [ADDR_W-1:0]    req_addr = '0;
    logic [DATA_W-1:0]    req_wdata = '0;
    logic [BYTE_EN_W-1:0] req_byteenable = '0;
    logic                 resp_valid;
    logic [DATA_W-1:0]    resp_rdata;
    logic                 resp_err;
    logic [ADDR_W-1:0]    address;
    logic                 write;
    logic                 read;
    logic                 waitrequest;
    logic [DATA_W-1:0]    writedata;
    logic [BYTE_EN_W-1:0] byteenable;
    logic [DATA_W-1:0]    readdata;

    always #5 clk = ~clk;

    bus_initiator #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_byteenable(req_byteenable),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    // Bus memory: 16 words, stalls each transfer for stall_n edges; waitrequest is
    // held high outside transfers, which the initiator must ignore.
    logic [31:0] bus_mem [16];
    int          stall_n = 0;
    int          stall_cnt = 0;
    logic        strobe;

    assign strobe      = read | write;
    assign waitrequest = strobe ? (stall_cnt < stall_n) : 1'b1;
    assign readdata    = bus_mem[address[5:2]];

    always @(posedge clk) begin
        if (strobe && waitrequest) stall_cnt <= stall_cnt + 1;
        else if (!strobe)          stall_cnt <= 0;
        if (write && !waitrequest) begin
            for (int b = 0; b < 4; b++)
                if (byteenable[b]) bus_mem[address[5:2]][8*b +: 8] <= writedata[8*b +: 8];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model state.
    logic        live = 1'b0;
    logic        s_rst_n = 1'b1, s_valid = 1'b0, s_write = 1'b0;
    logic [31:0] s_addr = '0, s_wdata = '0;
    logic [3:0]  s_be = '0;
    int          s_stall = 0;
    logic        m_ready = 1'b0, m_out = 1'b0, m_resp = 1'b0, m_acc_pulse = 1'b0, m_after_reset = 1'b0;
    logic        m_pend_write = 1'b0, m_pend_err = 1'b0, m_err = 1'b0;
    logic [31:0] m_pend_addr = '0, m_pend_wdata = '0, m_pend_rdata = '0, m_rdata = '0;
    logic [3:0]  m_pend_be = '0;
    int          m_resp_cyc = 0;
    int          acc_cycle = 0;
    int          dut_resp_cyc = 0;
    int          dut_resp_count = 0;
    int          read_cycles = 0;
    int          write_cycles = 0;
    int          idx = 0;
    logic [31:0] model_mem [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            bus_mem[i]   = 32'hCAFE_0000 + 32'(i);
            model_mem[i] = 32'hCAFE_0000 + 32'(i);
        end
    end

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            m_acc_pulse   = 1'b0;
            m_after_reset = 1'b0;
            if (!s_rst_n) begin
                live = 1'b1; m_out = 1'b0; m_resp = 1'b0;
                m_rdata = '0; m_err = 1'b0; m_after_reset = 1'b1;
            end else if (live) begin
                if (m_ready && s_valid) begin
                    m_acc_pulse  = 1'b1;
                    acc_cycle    = cyc - 1;
                    m_out        = 1'b1;
                    m_pend_write = s_write;
                    m_pend_addr  = s_addr & 32'hFFFF_FFFC;
                    m_pend_wdata = s_wdata;
                    m_pend_be    = s_be;
                    m_pend_err   = 1'b0;
                    m_pend_rdata = '0;
                    idx          = int'((s_addr >> 2) & 32'd15);
`ifdef BUS_TIMEOUT_EN
                    if (s_stall >= int'(TIMEOUT_CYCLES)) begin
                        m_resp_cyc = cyc + int'(TIMEOUT_CYCLES);
                        m_pend_err = 1'b1;
                    end else
`endif
                    if (s_stall == NEVER) begin
                        m_resp_cyc = NEVER;
                    end else begin
                        m_resp_cyc = cyc + 1 + s_stall;
                        if (s_write) begin
                            for (int b = 0; b < 4; b++)
                                if (s_be[b]) model_mem[idx][8*b +: 8] = s_wdata[8*b +: 8];
                        end else begin
                            m_pend_rdata = model_mem[idx];
                        end
                    end
                end
                m_resp = m_out && (cyc == m_resp_cyc);
                if (m_resp) begin
                    m_out   = 1'b0;
                    m_rdata = m_pend_rdata;
                    m_err   = m_pend_err;
                end
            end
            m_ready = !m_out && !m_resp;

            if (live) begin
                check("req_ready", req_ready, m_ready);
                check("resp_valid", resp_valid, m_resp);
                check("read", read, m_out && !m_pend_write);
                check("write", write, m_out && m_pend_write);
                check("resp_rdata", resp_rdata, m_rdata);
                check("resp_err", resp_err, m_err);
                if (m_out) begin
                    check("address", address, m_pend_addr);
                    check("writedata", writedata, m_pend_wdata);
                    check("byteenable", byteenable, m_pend_be);
                end
                if (m_after_reset) begin
                    check("rst_address", address, 0);
                    check("rst_writedata", writedata, 0);
                    check("rst_byteenable", byteenable, 0);
                end
                if (resp_valid === 1'b1) begin
                    dut_resp_cyc = cyc;
                    dut_resp_count++;
                end
                if (read === 1'b1)  read_cycles++;
                if (write === 1'b1) write_cycles++;
            end

            @(negedge clk);
            #3;
            s_rst_n = reset_n; s_valid = req_valid; s_write = req_write;
            s_addr  = req_addr; s_wdata = req_wdata; s_be = req_byteenable; s_stall = stall_n;
        end
    end

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int stall, input logic keep_valid,
                         output int acc);
        bit got;
        @(negedge clk);
        read_cycles = 0; write_cycles = 0;
        stall_n = stall; req_valid = 1'b1; req_write = wr;
        req_addr = addr; req_wdata = wdata; req_byteenable = be;
        got = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (m_acc_pulse) begin got = 1'b1; break; end
        end
        if (!got) check("accept_bound", 0, 1);
        acc = acc_cycle;
        if (!keep_valid) begin
            req_valid = 1'b0; req_write = ~wr;
            req_addr = $urandom; req_wdata = $urandom; req_byteenable = 4'($urandom);
        end
    endtask

    task automatic wait_idle(input int limit);
        bit got;
        got = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (m_ready && !m_out) begin got = 1'b1; break; end
        end
        if (!got) check("idle_bound", 0, 1);
    endtask

    initial begin : stimulus
        int acc, acc2, resp_before;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_addr", address, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, no wait states.
        issue(1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 1'b0, acc);
        wait_idle(50);
        check("rd0_latency", dut_resp_cyc - acc, 2);
        check("rd0_rdata", resp_rdata, 32'hCAFE_0000);
        check("rd0_err", resp_err, 0);
        check("rd0_read_cycles", read_cycles, 1);

        // Read, three wait states.
        issue(1'b0, 32'hBFC0_0008, 32'h0, 4'hF, 3, 1'b0, acc);
        wait_idle(50);
        check("rd3_latency", dut_resp_cyc - acc, 5);
        check("rd3_rdata", resp_rdata, 32'hCAFE_0002);
        check("rd3_read_cycles", read_cycles, 4);

        // Unaligned write of the low halfword, one wait state.
        issue(1'b1, 32'hBFC0_0007, 32'hDEAD_BEEF, 4'b0011, 1, 1'b0, acc);
        wait_idle(50);
        check("wr_latency", dut_resp_cyc - acc, 3);
        check("wr_rdata", resp_rdata, 0);
        check("wr_write_cycles", write_cycles, 2);
        check("wr_read_cycles", read_cycles, 0);
        check("wr_bus_mem", bus_mem[1], 32'hCAFE_BEEF);

        issue(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 0, 1'b0, acc);
        wait_idle(50);
        check("rdback_rdata", resp_rdata, 32'hCAFE_BEEF);

        // Back-to-back with req_valid held.
        issue(1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 0, 1'b1, acc);
        issue(1'b0, 32'hBFC0_000C, 32'h0, 4'hF, 0, 1'b0, acc2);
        wait_idle(50);
        check("b2b_accept_gap", acc2 - acc, 3);
        check("b2b_rdata", resp_rdata, 32'hCAFE_0003);

        // Completion on the last stall the watchdog tolerates.
        issue(1'b0, 32'hBFC0_0010, 32'h0, 4'hF, int'(TIMEOUT_CYCLES) - 1, 1'b0, acc);
        wait_idle(150);
        check("edge_latency", dut_resp_cyc - acc, int'(TIMEOUT_CYCLES) + 1);
        check("edge_rdata", resp_rdata, 32'hCAFE_0004);
        check("edge_err", resp_err, 0);

        // Reset while the bus is stalled.
        issue(1'b0, 32'hBFC0_0014, 32'h0, 4'hF, 10, 1'b0, acc);
        repeat (2) @(negedge clk);
        resp_before = dut_resp_count;
        reset_n = 1'b0;
        @(negedge clk);
        check("rstmid_read", read, 0);
        check("rstmid_rdata", resp_rdata, 0);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rstmid_no_resp", dut_resp_count, resp_before);
        check("rstmid_ready", req_ready, 1);

        // Bus stuck in waitrequest.
        issue(1'b0, 32'hBFC0_0018, 32'h0, 4'hF, NEVER, 1'b0, acc);
`ifdef BUS_TIMEOUT_EN
        wait_idle(150);
        check("to_latency", dut_resp_cyc - acc, int'(TIMEOUT_CYCLES) + 1);
        check("to_err", resp_err, 1);
        check("to_rdata", resp_rdata, 0);
`else
        resp_before = dut_resp_count;
        repeat (200) @(negedge clk);
        check("stuck_no_resp", dut_resp_count, resp_before);
        check("stuck_read", read, 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
`endif
        stall_n = 0;

        issue(1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 0, 1'b0, acc);
        wait_idle(50);
        check("recover_rdata", resp_rdata, 32'hCAFE_0000);
        check("recover_err", resp_err, 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : global_bound
        #100000;
        $display("FAIL global_timeout: still running at cycle %0d, limit 10000", cyc);
        $fatal(1, "bench did not terminate");
    end

endmodule
